// File: rtl/grid_cell_painter.sv
// Rasterises one grid cell (fill, border or erase) per request, one pixel per clock,
// for the VGA adapter plotting port. Start/ready/done handshake, err on bad requests.
module grid_cell_painter #(
  parameter int COORD_W  = 4,
  parameter int CLR_W    = 3,
  parameter int HPOS_W   = 8,
  parameter int VPOS_W   = 7,
  parameter int CELL     = 6,
  parameter int PITCH    = 7,
  parameter int X_ORIGIN = 28,
  parameter int Y_ORIGIN = 8,
  parameter int GRID_W   = 16,
  parameter int GRID_H   = 16,
  parameter int BG_CLR   = 0
) (
  input  logic               clk50,
  input  logic               reset,
  input  logic               start,
  input  logic [COORD_W-1:0] cell_x,
  input  logic [COORD_W-1:0] cell_y,
  input  logic [CLR_W-1:0]   clr_in,
  input  logic [1:0]         mode,
  output logic               ready,
  output logic               plot,
  output logic [HPOS_W-1:0]  hpos,
  output logic [VPOS_W-1:0]  vpos,
  output logic [CLR_W-1:0]   clr_out,
  output logic               done,
  output logic               err
);

  localparam int CNT_W = (CELL > 1) ? $clog2(CELL) : 1;

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_e;
  typedef enum logic [1:0] {
    M_FILL   = 2'b00,
    M_BORDER = 2'b01,
    M_ERASE  = 2'b10,
    M_RSVD   = 2'b11
  } mode_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   ix_q, ix_d, iy_q, iy_d;
  logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
  mode_e              mode_q, mode_d;
  logic [CLR_W-1:0]   clr_q, clr_d;

  logic               ready_d, plot_d, done_d, err_d;
  logic [HPOS_W-1:0]  hpos_d;
  logic [VPOS_W-1:0]  vpos_d;
  logic [CLR_W-1:0]   clr_out_d;

  logic req_ok, ix_last, iy_last, on_edge;

  always_comb begin
    req_ok  = (int'(cell_x) < GRID_W) && (int'(cell_y) < GRID_H) &&
              (mode_e'(mode) != M_RSVD);
    ix_last = (ix_q == CNT_W'(CELL - 1));
    iy_last = (iy_q == CNT_W'(CELL - 1));
    on_edge = (ix_q == '0) || ix_last || (iy_q == '0) || iy_last;

    state_d   = state_q;
    ix_d      = ix_q;
    iy_d      = iy_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    mode_d    = mode_q;
    clr_d     = clr_q;
    ready_d   = ready;
    plot_d    = 1'b0;
    hpos_d    = hpos;
    vpos_d    = vpos;
    clr_out_d = clr_out;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        // ready is the registered flag, so the cycle right after done still refuses start
        ready_d = 1'b1;
        if (ready && start) begin
          if (req_ok) begin
            cx_d    = cell_x;
            cy_d    = cell_y;
            mode_d  = mode_e'(mode);
            clr_d   = (mode_e'(mode) == M_ERASE) ? CLR_W'(BG_CLR) : clr_in;
            ix_d    = '0;
            iy_d    = '0;
            state_d = DRAW;
            ready_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DRAW: begin
        plot_d    = (mode_q != M_BORDER) || on_edge;
        hpos_d    = HPOS_W'(X_ORIGIN) + HPOS_W'(cx_q) * HPOS_W'(PITCH) + HPOS_W'(ix_q);
        vpos_d    = VPOS_W'(Y_ORIGIN) + VPOS_W'(cy_q) * VPOS_W'(PITCH) + VPOS_W'(iy_q);
        clr_out_d = clr_q;
        if (ix_last) begin
          ix_d = '0;
          if (iy_last) state_d = DONE;
          else         iy_d    = iy_q + 1'b1;
        end else begin
          ix_d = ix_q + 1'b1;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk50) begin
    if (reset) begin
      state_q <= IDLE;
      ix_q    <= '0;
      iy_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      mode_q  <= M_FILL;
      clr_q   <= '0;
      ready   <= 1'b1;
      plot    <= 1'b0;
      hpos    <= '0;
      vpos    <= '0;
      clr_out <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      ix_q    <= ix_d;
      iy_q    <= iy_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      mode_q  <= mode_d;
      clr_q   <= clr_d;
      ready   <= ready_d;
      plot    <= plot_d;
      hpos    <= hpos_d;
      vpos    <= vpos_d;
      clr_out <= clr_out_d;
      done    <= done_d;
      err     <= err_d;
    end
  end

endmodule

// File: tb/tb_grid_cell_painter.sv
// Bench for grid_cell_painter: per-cycle comparison against a queue-based request model,
// plus literal pixel/count expectations for the directed cases.
module tb_grid_cell_painter;

  localparam int CELL = 6;
  localparam int PITCH = 7;
  localparam int XO = 28;
  localparam int YO = 8;

  logic       clk50 = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] cell_x = '0, cell_y = '0;
  logic [2:0] clr_in = '0;
  logic [1:0] mode = '0;
  logic       ready, plot, done, err;
  logic [7:0] hpos;
  logic [6:0] vpos;
  logic [2:0] clr_out;

  logic       start2 = 1'b0;
  logic [3:0] cell_x2 = '0, cell_y2 = '0;
  logic [2:0] clr_in2 = '0;
  logic [1:0] mode2 = '0;
  logic       ready2, plot2, done2, err2;
  logic [7:0] hpos2;
  logic [6:0] vpos2;
  logic [2:0] clr_out2;

  grid_cell_painter dut (
    .clk50(clk50), .reset(reset), .start(start), .cell_x(cell_x), .cell_y(cell_y),
    .clr_in(clr_in), .mode(mode), .ready(ready), .plot(plot), .hpos(hpos), .vpos(vpos),
    .clr_out(clr_out), .done(done), .err(err)
  );

  grid_cell_painter #(.GRID_W(10)) dut2 (
    .clk50(clk50), .reset(reset), .start(start2), .cell_x(cell_x2), .cell_y(cell_y2),
    .clr_in(clr_in2), .mode(mode2), .ready(ready2), .plot(plot2), .hpos(hpos2), .vpos(vpos2),
    .clr_out(clr_out2), .done(done2), .err(err2)
  );

  always #10 clk50 = ~clk50;

  typedef struct {
    bit plot;
    int h;
    int v;
    int c;
    bit done;
    bit ready;
    bit err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;

  int plot_cnt, done_cnt, first_h, first_v, last_h, last_v;
  int min_h, max_h, min_v, max_v, max_c;
  bit seen[int];
  int plot2_cnt = 0;
  int done2_cnt = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t idle_exp();
    exp_t e;
    e.plot = 0; e.h = 0; e.v = 0; e.c = 0;
    e.done = 0; e.ready = 1; e.err = 0;
    return e;
  endfunction

  // Expected output stream, one entry per clock starting with the acceptance edge.
  task automatic model_req(input int x, input int y, input int c, input int m);
    exp_t e;
    e = idle_exp();
    if (x >= 16 || y >= 16 || m == 3) begin
      e.err = 1;
      exp_q.push_back(e);
      return;
    end
    e.ready = 0;
    exp_q.push_back(e);
    for (int iy = 0; iy < CELL; iy++) begin
      for (int ix = 0; ix < CELL; ix++) begin
        e.plot = (m != 1) || ix == 0 || ix == CELL - 1 || iy == 0 || iy == CELL - 1;
        e.h = (XO + x * PITCH + ix) % 256;
        e.v = (YO + y * PITCH + iy) % 128;
        e.c = (m == 2) ? 0 : c;
        exp_q.push_back(e);
      end
    end
    e = idle_exp();
    e.ready = 0;
    e.done = 1;
    exp_q.push_back(e);
  endtask

  always @(negedge clk50) begin
    exp_t e;
    if (cmp_en) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = idle_exp();
      chk("ready", ready, e.ready);
      chk("plot", plot, e.plot);
      chk("done", done, e.done);
      chk("err", err, e.err);
      if (e.plot && plot) begin
        chk("hpos", hpos, e.h);
        chk("vpos", vpos, e.v);
        chk("clr_out", clr_out, e.c);
      end
      if (plot) begin
        plot_cnt++;
        if (plot_cnt == 1) begin first_h = hpos; first_v = vpos; end
        last_h = hpos; last_v = vpos;
        if (int'(hpos) < min_h) min_h = hpos;
        if (int'(hpos) > max_h) max_h = hpos;
        if (int'(vpos) < min_v) min_v = vpos;
        if (int'(vpos) > max_v) max_v = vpos;
        if (int'(clr_out) > max_c) max_c = clr_out;
        seen[int'(hpos) * 128 + int'(vpos)] = 1'b1;
      end
      if (done) done_cnt++;
      if (plot2) plot2_cnt++;
      if (done2) done2_cnt++;
    end
  end

  task automatic clear_log();
    plot_cnt = 0; done_cnt = 0;
    first_h = -1; first_v = -1; last_h = -1; last_v = -1;
    min_h = 1000; max_h = -1; min_v = 1000; max_v = -1; max_c = 0;
    seen.delete();
  endtask

  task automatic issue(input int x, input int y, input int c, input int m);
    @(posedge clk50); #1;
    cell_x = 4'(x); cell_y = 4'(y); clr_in = 3'(c); mode = 2'(m);
    start = 1'b1;
    @(posedge clk50); #1;
    start = 1'b0;
    model_req(x, y, c, m);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(posedge clk50);
      n++;
    end
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    clear_log();
    repeat (3) @(posedge clk50);
    #1;
    reset = 1'b0;
    chk("rst_ready", ready, 1);
    chk("rst_plot", plot, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_hpos", hpos, 0);
    chk("rst_vpos", vpos, 0);
    chk("rst_clr", clr_out, 0);
    cmp_en = 1'b1;

    // FILL (0,0) colour 3
    clear_log();
    issue(0, 0, 3, 0);
    wait_idle("fill00_drain", 60);
    chk("fill00_plots", plot_cnt, 36);
    chk("fill00_first_h", first_h, 28);
    chk("fill00_first_v", first_v, 8);
    chk("fill00_last_h", last_h, 33);
    chk("fill00_last_v", last_v, 13);
    chk("fill00_done", done_cnt, 1);

    // FILL (15,15) colour 5: far corner, no wrap
    clear_log();
    issue(15, 15, 5, 0);
    wait_idle("fill1515_drain", 60);
    chk("fill1515_plots", plot_cnt, 36);
    chk("fill1515_min_h", min_h, 133);
    chk("fill1515_max_h", max_h, 138);
    chk("fill1515_min_v", min_v, 113);
    chk("fill1515_max_v", max_v, 118);

    // BORDER (2,1) colour 7
    clear_log();
    issue(2, 1, 7, 1);
    wait_idle("border_drain", 60);
    chk("border_plots", plot_cnt, 20);
    chk("border_interior", int'(seen.exists(44 * 128 + 17)), 0);
    chk("border_c00", int'(seen.exists(42 * 128 + 15)), 1);
    chk("border_c10", int'(seen.exists(47 * 128 + 15)), 1);
    chk("border_c01", int'(seen.exists(42 * 128 + 20)), 1);
    chk("border_c11", int'(seen.exists(47 * 128 + 20)), 1);
    chk("border_done", done_cnt, 1);

    // ERASE (4,4) with clr_in 6 writes background
    clear_log();
    issue(4, 4, 6, 2);
    wait_idle("erase_drain", 60);
    chk("erase_plots", plot_cnt, 36);
    chk("erase_max_clr", max_c, 0);

    // reserved mode rejected
    clear_log();
    issue(3, 3, 4, 3);
    wait_idle("rsvd_drain", 10);
    repeat (3) @(posedge clk50);
    chk("rsvd_plots", plot_cnt, 0);
    chk("rsvd_done", done_cnt, 0);

    // GRID_W=10 instance: column 10 rejected, column 9 accepted
    @(posedge clk50); #1;
    cell_x2 = 4'd10; cell_y2 = 4'd0; mode2 = 2'b00; clr_in2 = 3'd1; start2 = 1'b1;
    @(posedge clk50); #1;
    start2 = 1'b0;
    chk("g10_err", err2, 1);
    chk("g10_ready", ready2, 1);
    chk("g10_plot", plot2, 0);
    @(posedge clk50); #1;
    chk("g10_err_width", err2, 0);
    chk("g10_ready2", ready2, 1);
    chk("g10_plots", plot2_cnt, 0);
    chk("g10_dones", done2_cnt, 0);
    cell_x2 = 4'd9; start2 = 1'b1;
    @(posedge clk50); #1;
    start2 = 1'b0;
    chk("g9_ready", ready2, 0);
    chk("g9_err", err2, 0);
    repeat (40) @(posedge clk50);
    #1;
    chk("g9_dones", done2_cnt, 1);
    chk("g9_plots", plot2_cnt, 36);
    chk("g9_ready_after", ready2, 1);

    // reset on the 10th DRAW cycle abandons the request
    clear_log();
    issue(1, 1, 2, 0);
    repeat (9) @(posedge clk50);
    #1;
    reset = 1'b1;
    @(posedge clk50); #1;
    exp_q.delete();
    @(posedge clk50); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk50);
    chk("rstmid_plots", plot_cnt, 9);
    chk("rstmid_done", done_cnt, 0);
    clear_log();
    issue(5, 6, 1, 0);
    wait_idle("after_rst_drain", 60);
    chk("after_rst_plots", plot_cnt, 36);
    chk("after_rst_done", done_cnt, 1);

    // second start during DRAW is ignored
    clear_log();
    issue(3, 2, 2, 0);
    repeat (5) @(posedge clk50);
    #1;
    cell_x = 4'd7; cell_y = 4'd7; mode = 2'b01; clr_in = 3'd1; start = 1'b1;
    repeat (2) @(posedge clk50);
    #1;
    start = 1'b0;
    wait_idle("middraw_drain", 60);
    repeat (5) @(posedge clk50);
    chk("middraw_plots", plot_cnt, 36);
    chk("middraw_done", done_cnt, 1);

    @(negedge clk50);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
